// File: rtl/regfile_pc_gen.sv
// Register file with integrated program counter.
// Provides two combinational read ports, one write port and a PC with
// load/increment. A link write stores the return address for calls.
// Optional write-to-read bypass and an optional hardwired-zero R0 are available.
module regfile_pc_gen #(
   parameter int unsigned       DATA_W   = 8,
   parameter int unsigned       ADDR_W   = 2,
   parameter logic [DATA_W-1:0] RESET_PC = '0,
   parameter int unsigned       PC_STEP  = 1,
   parameter int unsigned       LINK_REG = 3,
   parameter int unsigned       BYPASS   = 1,
   parameter int unsigned       ZERO_R0  = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   input  logic              pc_inc,
   input  logic              pc_load,
   input  logic [DATA_W-1:0] pc_target,
   input  logic              link_en,
   output logic [DATA_W-1:0] pc_out,
   output logic [DATA_W-1:0] pc_next
);

   localparam int unsigned       NUM_REGS  = 2 ** ADDR_W;
   localparam logic [DATA_W-1:0] STEP      = DATA_W'(PC_STEP);
   localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);
   localparam bit                HAS_ZERO  = (ZERO_R0 != 0);
   localparam bit                HAS_BYP   = (BYPASS != 0);
   // A link aimed at a hardwired-zero R0 has nowhere to land.
   localparam bit                LINK_LIVE = !(HAS_ZERO && (LINK_REG == 0));

   // Parameter sanity checks at elaboration
   if (LINK_REG >= NUM_REGS) begin : g_bad_link
      $fatal(1, "regfile_pc_gen: LINK_REG must be below NUM_REGS");
   end
   if (DATA_W < 2) begin : g_bad_data_w
      $fatal(1, "regfile_pc_gen: DATA_W must be at least 2");
   end
   if (ADDR_W < 1) begin : g_bad_addr_w
      $fatal(1, "regfile_pc_gen: ADDR_W must be at least 1");
   end

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-1:0] pc;
   logic [DATA_W-1:0] link_val;
   logic              wr_ok;
   logic              link_ok;

   assign pc_out   = pc;
   assign link_val = pc + STEP;
   assign wr_ok    = we && !(HAS_ZERO && (waddr == '0));
   assign link_ok  = link_en && LINK_LIVE;

   // Next PC: reset vector, then load, then increment, else hold
   always_comb begin
      pc_next = pc;
      if (reset) begin
         pc_next = RESET_PC;
      end else if (pc_load) begin
         pc_next = pc_target;
      end else if (pc_inc) begin
         pc_next = pc + STEP;
      end
   end

   // One read port: zero R0 first, then link/write forwarding, then storage
   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
      logic [DATA_W-1:0] val;
      val = regs[addr];
      if (HAS_BYP && wr_ok && (waddr == addr)) begin
         val = wdata;
      end
      if (HAS_BYP && link_ok && (LINK_ADDR == addr)) begin
         val = link_val;
      end
      if (HAS_ZERO && (addr == '0)) begin
         val = '0;
      end
      return val;
   endfunction

   // Combinational read ports
   always_comb begin
      rdata1 = read_port(raddr1);
      rdata2 = read_port(raddr2);
   end

   // State update: reset clears everything, link beats a same-address write
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         pc <= RESET_PC;
      end else begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (link_ok && (LINK_ADDR == ADDR_W'(i))) begin
               regs[i] <= link_val;
            end else if (wr_ok && (waddr == ADDR_W'(i))) begin
               regs[i] <= wdata;
            end
         end
         pc <= pc_next;
      end
   end

endmodule

// File: tb/tb_regfile_pc_gen.sv
// Scoreboard bench for regfile_pc_gen: two configurations driven in parallel.
// Instance A uses default parameters.
// Instance B uses RESET_PC=0x10, PC_STEP=2, LINK_REG=1, no bypass and zero R0.
module tb_regfile_pc_gen;

   logic       clk = 1'b0;
   logic       reset, we, pc_inc, pc_load, link_en;
   logic [1:0] waddr, raddr1, raddr2;
   logic [7:0] wdata, pc_target;
   logic [7:0] rd1_a, rd2_a, pco_a, pcn_a;
   logic [7:0] rd1_b, rd2_b, pco_b, pcn_b;

   always #5 clk = ~clk;

   regfile_pc_gen dut_a (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_a), .rdata2(rd2_a),
      .pc_inc(pc_inc), .pc_load(pc_load), .pc_target(pc_target),
      .link_en(link_en), .pc_out(pco_a), .pc_next(pcn_a)
   );

   regfile_pc_gen #(
      .DATA_W(8), .ADDR_W(2), .RESET_PC(8'h10), .PC_STEP(2),
      .LINK_REG(1), .BYPASS(0), .ZERO_R0(1)
   ) dut_b (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_b), .rdata2(rd2_b),
      .pc_inc(pc_inc), .pc_load(pc_load), .pc_target(pc_target),
      .link_en(link_en), .pc_out(pco_b), .pc_next(pcn_b)
   );

   typedef struct {
      logic       rst, we, inc, ld, lk;
      logic [1:0] wa, ra1, ra2;
      logic [7:0] wd, tgt;
   } stim_t;

   typedef struct {
      logic [1:0][7:0] r1, r2, pco, pcn;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   bit   drv_done = 1'b0;

   // Reference model: per-config constants and architectural state
   int         c_rst [2] = '{8'h00, 8'h10};
   int         c_step[2] = '{1, 2};
   int         c_link[2] = '{3, 1};
   bit         c_byp [2] = '{1'b1, 1'b0};
   bit         c_z0  [2] = '{1'b0, 1'b1};
   int         m_regs[2][4];
   int         m_pc  [2];

   function automatic int wrap(input int v);
      return v % 256;
   endfunction

   function automatic int exp_read(input int d, input stim_t s, input int a);
      if (c_z0[d] && a == 0) return 0;
      if (c_byp[d]) begin
         if (s.lk && a == c_link[d]) return wrap(m_pc[d] + c_step[d]);
         if (s.we && a == int'(s.wa)) return int'(s.wd);
      end
      return m_regs[d][a];
   endfunction

   function automatic int exp_pc_next(input int d, input stim_t s);
      if (s.rst) return c_rst[d];
      if (s.ld)  return int'(s.tgt);
      if (s.inc) return wrap(m_pc[d] + c_step[d]);
      return m_pc[d];
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int r = 0; r < 4; r++) m_regs[d][r] = 0;
         m_pc[d] = c_rst[d];
      end
   endtask

   // Drive one cycle, queue the expected outputs, then advance the model
   task automatic step(input stim_t s);
      exp_t e;
      int   nx;
      reset = s.rst; we = s.we; waddr = s.wa; wdata = s.wd;
      raddr1 = s.ra1; raddr2 = s.ra2; pc_inc = s.inc; pc_load = s.ld;
      pc_target = s.tgt; link_en = s.lk;
      for (int d = 0; d < 2; d++) begin
         e.r1[d]  = 8'(exp_read(d, s, int'(s.ra1)));
         e.r2[d]  = 8'(exp_read(d, s, int'(s.ra2)));
         e.pco[d] = 8'(m_pc[d]);
         e.pcn[d] = 8'(exp_pc_next(d, s));
      end
      exp_q.push_back(e);
      if (s.rst) begin
         model_reset();
      end else begin
         for (int d = 0; d < 2; d++) begin
            nx = exp_pc_next(d, s);
            if (s.we && !(c_z0[d] && s.wa == 2'd0)) m_regs[d][s.wa] = int'(s.wd);
            if (s.lk && !(c_z0[d] && c_link[d] == 0))
               m_regs[d][c_link[d]] = wrap(m_pc[d] + c_step[d]);
            m_pc[d] = nx;
         end
      end
      @(posedge clk);
      #1;
   endtask

   function automatic stim_t idle(input logic [1:0] a1, input logic [1:0] a2);
      stim_t s;
      s = '{rst: 1'b0, we: 1'b0, inc: 1'b0, ld: 1'b0, lk: 1'b0,
            wa: 2'd0, ra1: a1, ra2: a2, wd: 8'h00, tgt: 8'h00};
      return s;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, expv);
      end
   endtask

   // Monitor: outputs are stable mid-cycle, compare against the queue head
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("a_rdata1",  rd1_a, e.r1[0]);
            chk("a_rdata2",  rd2_a, e.r2[0]);
            chk("a_pc_out",  pco_a, e.pco[0]);
            chk("a_pc_next", pcn_a, e.pcn[0]);
            chk("b_rdata1",  rd1_b, e.r1[1]);
            chk("b_rdata2",  rd2_b, e.r2[1]);
            chk("b_pc_out",  pco_b, e.pco[1]);
            chk("b_pc_next", pcn_b, e.pcn[1]);
         end
      end
   end

   // Stimulus: reset, directed scenarios, then random traffic
   initial begin
      stim_t s;
      s = idle(2'd0, 2'd1);
      s.rst = 1'b1;
      reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
      pc_inc = 1'b0; pc_load = 1'b0; pc_target = '0; link_en = 1'b0;
      @(posedge clk);
      #1;
      model_reset();

      // Reset state on all registers
      step(idle(2'd0, 2'd1));
      step(idle(2'd2, 2'd3));

      // Write with same-cycle read
      s = idle(2'd2, 2'd1); s.we = 1'b1; s.wa = 2'd2; s.wd = 8'hA5;
      step(s);
      step(idle(2'd2, 2'd2));

      // PC wrap
      s = idle(2'd0, 2'd0); s.ld = 1'b1; s.tgt = 8'hFE; step(s);
      s = idle(2'd0, 2'd0); s.inc = 1'b1; step(s); step(s);
      step(idle(2'd0, 2'd0));

      // Load wins over increment
      s = idle(2'd0, 2'd0); s.inc = 1'b1; s.ld = 1'b1; s.tgt = 8'h40; step(s);
      step(idle(2'd0, 2'd0));

      // Call: link, load and a colliding write to R3
      s = idle(2'd0, 2'd0); s.ld = 1'b1; s.tgt = 8'h20; step(s);
      s = idle(2'd3, 2'd1); s.lk = 1'b1; s.ld = 1'b1; s.tgt = 8'h80;
      s.we = 1'b1; s.wa = 2'd3; s.wd = 8'h55; step(s);
      step(idle(2'd3, 2'd1));

      // Write to R0
      s = idle(2'd0, 2'd0); s.we = 1'b1; s.wa = 2'd0; s.wd = 8'h77; step(s);
      step(idle(2'd0, 2'd0));

      // Reset during a write and an increment, then resume
      s = idle(2'd0, 2'd0); s.ld = 1'b1; s.tgt = 8'h05; step(s);
      s = idle(2'd1, 2'd0); s.rst = 1'b1; s.we = 1'b1; s.wa = 2'd1; s.wd = 8'h33;
      s.inc = 1'b1; step(s);
      step(idle(2'd1, 2'd2));
      s = idle(2'd1, 2'd3); s.we = 1'b1; s.wa = 2'd1; s.wd = 8'h44; s.inc = 1'b1; step(s);
      step(idle(2'd1, 2'd3));

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         s.rst = ($urandom_range(0, 39) == 0);
         s.we  = 1'($urandom_range(0, 1));
         s.inc = 1'($urandom_range(0, 1));
         s.ld  = ($urandom_range(0, 7) == 0);
         s.lk  = ($urandom_range(0, 7) == 0);
         s.wa  = 2'($urandom_range(0, 3));
         s.ra1 = 2'($urandom_range(0, 3));
         s.ra2 = 2'($urandom_range(0, 3));
         s.wd  = 8'($urandom_range(0, 255));
         s.tgt = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
         step(s);
      end
      step(idle(2'd0, 2'd1));
      drv_done = 1'b1;
   end

   // End of run: drain the scoreboard with a bounded wait
   initial begin
      wait (drv_done);
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain left=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "timeout");
   end

endmodule
